// File: rtl/combo_decoder.sv
// Per-player move decoder: synchronizes debounced buttons, keeps a short
// directional history and resolves punch presses into special-move combos.
module combo_decoder #(
   parameter int unsigned STEP_TIMEOUT = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       facingRight,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnC,
   output logic       comboValid,
   output logic [1:0] comboId,
   output logic       busy
);

   localparam int NUM_BTN = 5;
   localparam int CNT_W   = 25;

   typedef enum logic [2:0] {
      TOK_EMPTY = 3'd0,
      TOK_UP    = 3'd1,
      TOK_DOWN  = 3'd2,
      TOK_FWD   = 3'd3,
      TOK_BACK  = 3'd4
   } token_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] id;
   } comboRsp_t;

   // Bit order {C, R, L, D, U}
   logic [NUM_BTN-1:0]       btnRaw;
   logic [3:1][NUM_BTN-1:0]  syncPipe;
   logic [NUM_BTN-1:0]       press;

   assign btnRaw = {btnC, btnR, btnL, btnD, btnU};

   // Stages 1-2 synchronize, stage 3 remembers the previous level for edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) syncPipe <= '0;
      else        syncPipe <= {syncPipe[2:1], btnRaw};
   end

   assign press = syncPipe[2] & ~syncPipe[3];

   token_t          h0, h1, h2;
   logic [CNT_W-1:0] stepCnt;
   comboRsp_t       rsp;

   logic       punch, push, pFwd, pBack, timeout;
   token_t     pushTok;
   logic [1:0] matchId;

   assign punch = press[4];
   assign pFwd  = facingRight ? press[3] : press[2];
   assign pBack = facingRight ? press[2] : press[3];

   always_comb begin
      pushTok = TOK_EMPTY;
      if (!punch) begin
         if      (press[1]) pushTok = TOK_DOWN;
         else if (pFwd)     pushTok = TOK_FWD;
         else if (pBack)    pushTok = TOK_BACK;
         else if (press[0]) pushTok = TOK_UP;
      end
   end

   assign push = (pushTok != TOK_EMPTY);

   // Longest pattern first so FWD,DOWN,FWD is never reported as hadouken.
   always_comb begin
      matchId = 2'd0;
      if (h2 == TOK_FWD && h1 == TOK_DOWN && h0 == TOK_FWD) matchId = 2'd2;
      else if (h1 == TOK_DOWN && h0 == TOK_FWD)             matchId = 2'd1;
      else if (h1 == TOK_DOWN && h0 == TOK_BACK)            matchId = 2'd3;
   end

   assign busy    = (h0 != TOK_EMPTY);
   assign timeout = busy && (stepCnt == CNT_W'(STEP_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h0      <= TOK_EMPTY;
         h1      <= TOK_EMPTY;
         h2      <= TOK_EMPTY;
         stepCnt <= '0;
         rsp     <= '0;
      end else begin
         rsp <= '0;
         if (!enable || punch || (!push && (timeout || !busy))) begin
            if (enable && punch) rsp <= '{valid: 1'b1, id: matchId};
            h0      <= TOK_EMPTY;
            h1      <= TOK_EMPTY;
            h2      <= TOK_EMPTY;
            stepCnt <= '0;
         end else if (push) begin
            // A push on the expiry edge starts a fresh history.
            h0      <= pushTok;
            h1      <= timeout ? TOK_EMPTY : h0;
            h2      <= timeout ? TOK_EMPTY : h1;
            stepCnt <= '0;
         end else begin
            stepCnt <= stepCnt + 1'b1;
         end
      end
   end

   assign comboValid = rsp.valid;
   assign comboId    = rsp.id;

endmodule

// File: tb/tb_combo_decoder.sv
// Scoreboard bench for combo_decoder: expected combos are queued when the
// punch is driven and retired when the pulse appears.
module tb_combo_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       facingRight;
   logic [4:0] btns;        // {C, R, L, D, U}
   logic       comboValid;
   logic [1:0] comboId;
   logic       busy;

   localparam int B_U = 0, B_D = 1, B_L = 2, B_R = 3, B_C = 4;

   combo_decoder #(.STEP_TIMEOUT(100)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .facingRight(facingRight),
      .btnU(btns[B_U]), .btnD(btns[B_D]), .btnL(btns[B_L]),
      .btnR(btns[B_R]), .btnC(btns[B_C]),
      .comboValid(comboValid), .comboId(comboId), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t eMon;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   pulseCnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0d exp=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && comboValid === 1'b1) begin
         pulseCnt++;
         if (sb.size() == 0) chk("spurious_pulse", 1, 0);
         else begin
            eMon = sb.pop_front();
            chk("comboId", comboId, eMon.id);
            chk("latency", cyc, eMon.cyc);
         end
      end
   end

   // expId < 0: no pulse expected from this press
   task automatic press(input int b, input int expId);
      exp_t e;
      @(negedge clk);
      btns[b] = 1'b1;
      if (expId >= 0) begin
         e.id = expId; e.cyc = cyc + 3;
         sb.push_back(e);
      end
      repeat (3) @(negedge clk);
      btns[b] = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic waitCyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   int c, pc;
   exp_t e;

   initial begin
      rst_n = 1'b0; enable = 1'b1; facingRight = 1'b1; btns = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", comboValid, 0);
      chk("rst_id", comboId, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Hadouken facing right
      press(B_D, -1);
      chk("had_busy", busy, 1);
      press(B_R, -1);
      press(B_C, 1);
      chk("had_busy_after", busy, 0);

      // Facing left: L is forward
      facingRight = 1'b0;
      press(B_L, -1); press(B_D, -1); press(B_L, -1); press(B_C, 2);
      press(B_R, -1); press(B_D, -1); press(B_R, -1); press(B_C, 3);
      chk("mirror_busy_after", busy, 0);

      // Timeout: busy falls exactly 100 clocks after the D push
      facingRight = 1'b1;
      @(negedge clk); btns[B_D] = 1'b1; c = cyc;
      repeat (3) @(negedge clk); btns[B_D] = 1'b0;
      waitCyc(c + 102);
      chk("to_busy_before", busy, 1);
      @(negedge clk);
      chk("to_busy_fall", busy, 0);
      press(B_R, -1);
      press(B_C, 0);

      // Push landing on the expiry edge wins and starts fresh history
      @(negedge clk); btns[B_D] = 1'b1; c = cyc;
      repeat (3) @(negedge clk); btns[B_D] = 1'b0;
      waitCyc(c + 100);
      btns[B_R] = 1'b1;
      repeat (3) @(negedge clk);
      chk("bnd_busy", busy, 1);
      btns[B_R] = 1'b0;
      repeat (6) @(negedge clk);
      press(B_C, 0);

      // D and C on the same clock: punch wins, D discarded
      press(B_D, -1);
      @(negedge clk);
      btns[B_D] = 1'b1; btns[B_C] = 1'b1;
      e.id = 0; e.cyc = cyc + 3; sb.push_back(e);
      repeat (3) @(negedge clk);
      btns = '0;
      repeat (6) @(negedge clk);
      chk("sim_busy", busy, 0);

      // Disabled player: no pushes, no pulses
      pc = pulseCnt;
      enable = 1'b0;
      press(B_D, -1);
      chk("dis_busy", busy, 0);
      press(B_R, -1); press(B_C, -1);
      chk("dis_pulses", pulseCnt, pc);
      // Held button while enable rises: edge already consumed
      @(negedge clk); btns[B_D] = 1'b1;
      repeat (5) @(negedge clk); enable = 1'b1;
      repeat (5) @(negedge clk);
      chk("held_busy", busy, 0);
      btns[B_D] = 1'b0;
      repeat (4) @(negedge clk);
      press(B_C, 0);

      // Reset during the pulse cycle
      press(B_D, -1); press(B_R, -1);
      pc = pulseCnt;
      @(negedge clk); btns[B_C] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_pulse_up", comboValid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", comboValid, 0);
      chk("mid_rst_id", comboId, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk); btns[B_C] = 1'b0;
      repeat (2) @(negedge clk); rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_pulses", pulseCnt, pc);
      press(B_C, 0);

      repeat (10) @(negedge clk);
      chk("sb_pending", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/combo_decoder.md
# combo_decoder

Turns the debounced button levels of one player into move commands. It detects press edges, maps left/right to forward/back using the player's facing, and holds a short history of directional presses. When the punch button is pressed, it reports either a special-move combo or a plain punch. It sits between the per-button debouncers and the fighter state machine, one instance per player.

## Interface
- `STEP_TIMEOUT`, default 25_000_000: maximum clocks allowed between consecutive directional presses (250 ms at 100 MHz). Range 2 to 2^25-1.
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst_n` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `enable` input, 1 bit: player may act. Low means the player is stunned or the round is inactive.
- `facingRight` input, 1 bit: 1 means the player faces right.
- `btnU`, `btnD`, `btnL`, `btnR`, `btnC` inputs, 1 bit each: debounced button levels, active-high. They are asynchronous to `clk` because they come from the 20 Hz debounce clock.
- `comboValid` output, 1 bit: one-cycle pulse when a punch press resolves.
- `comboId` output, 2 bits: 0 plain punch, 1 hadouken, 2 shoryuken, 3 tatsumaki. Valid only while `comboValid` is high and 0 otherwise.
- `busy` output, 1 bit: history is non-empty.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer, then a third flop used for edge detection. A press is `sync2 & ~sync3`. These flops run regardless of `enable`.
- **Tokens (3-bit):** 0 EMPTY, 1 UP, 2 DOWN, 3 FWD, 4 BACK.
  - `facingRight`=1: `btnR`=FWD, `btnL`=BACK.
  - `facingRight`=0: the mapping is swapped.
  - `facingRight` is sampled at the same edge as the press.
- **Press priority per cycle:** C > D > FWD > BACK > U. Only the highest-priority press in a cycle is used; the others in that cycle are discarded.
- **History:** 3-entry shift register of directional tokens, newest at h0. Push shifts h0→h1→h2 and discards h2. `busy` = (h0 != EMPTY).
- **Punch resolution:** on a C press, match the current history, longest pattern first, newest-last order:
  - shoryuken: h2,h1,h0 = FWD,DOWN,FWD → `comboId`=2.
  - hadouken: h1,h0 = DOWN,FWD → 1.
  - tatsumaki: h1,h0 = DOWN,BACK → 3.
  - otherwise → 0.
  - Then pulse `comboValid` and clear the whole history.
- **Timeout counter (25-bit):**
  - Cleared on any push, on a punch, and whenever history is empty.
  - Increments each cycle while `busy`.
  - When it equals `STEP_TIMEOUT-1`, the history and counter clear at the next edge.
- **Simultaneous push and timeout:** the push wins. History becomes {EMPTY, EMPTY, new token} and the counter goes to 0.
- **Simultaneous punch and timeout:** the punch resolves against the pre-timeout history, then everything clears.
- **`enable`=0:** history and counter are held cleared, and presses are ignored (no push, no pulse). A button held while `enable` rises produces no press, because the edge was already consumed.
- **Reset values:** all flops 0, `comboValid`=0, `comboId`=0, `busy`=0. A button held through reset release produces one press about 3 clocks later.

## Timing
- A button level first sampled high at edge k gives: `sync1`=1 after k, `sync2`=1 after k+1, and the press is seen combinationally before edge k+2.
- At edge k+2, the history push or punch resolution happens. `comboValid` and `comboId` are registered and high for exactly the cycle after k+2.
- `busy` rises after edge k+2 for a directional press.
- Back-to-back presses on different buttons in consecutive cycles are each processed, subject to the per-cycle priority rule.
- A button must return low for at least 2 clocks to re-arm its edge detector. At 20 Hz debounced input this always holds.
- Asynchronous `rst_n` assertion clears all outputs immediately, including in mid-pulse.

## Test plan
- **Hadouken:** `facingRight`=1, press D, then R 10 clocks later, then C 10 clocks later → single `comboValid` with `comboId`=1, 3 clocks after C rises; `busy`=0 afterwards.
- **Facing mirror and longest match:**
  - `facingRight`=0, press L, D, L, C → `comboId`=2.
  - Repeat with R instead of L → D,BACK history (not FWD,DOWN,FWD) → `comboId`=3.
- **Timeout:** with `STEP_TIMEOUT`=100, press D, wait 100 clocks, press R, press C → `comboId`=0. `busy` falls exactly 100 clocks after the D push.
- **Timeout boundary:** `STEP_TIMEOUT`=100, press R so that its push lands on the expiry edge → history = {R only}; a following C gives `comboId`=0.
- **Simultaneous edges:** D and C rise on the same clock with history = DOWN → C wins, `comboId`=0, history cleared, D press discarded.
- **Enable and reset:**
  - Hold `enable`=0 while pressing D, R, C → no `comboValid`.
  - Assert `rst_n`=0 one cycle after a C press edge → `comboValid`=0 immediately and no pulse after release.
